// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order holding queue for pshare predictions.
// Each queued prediction waits for the real outcome. The queue then emits a
// registered training update and keeps branch and mispredict counts.
// A mispredict discards every younger (wrong-path) entry. Intake then stalls
// for one recovery cycle.
// Optional feature: define BRQ_TARGET_CHECK_EN to store and compare targets.
// When it is undefined, a mispredict is a direction mismatch only.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | normal operation, pushes and pops allowed
//   ST_RECOVER | one cycle after a flush, intake stalled, resolutions orphaned
module branch_resolve_queue #(
  parameter int Direction_SIZE = 32,
  parameter int DEPTH          = 8,
  parameter int CNT_W          = 33
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pred_valid,
  output logic                      pred_ready,
  input  logic [Direction_SIZE-1:0] pred_pc,
  input  logic                      pred_taken,
  input  logic [Direction_SIZE-1:0] pred_target,
  input  logic                      res_valid,
  input  logic                      res_taken,
  input  logic [Direction_SIZE-1:0] res_target,
  output logic                      upd_valid,
  output logic [Direction_SIZE-1:0] upd_pc,
  output logic                      upd_taken,
  output logic                      upd_mispredict,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      res_orphan,
  output logic [CNT_W-1:0]          total_branch,
  output logic [CNT_W-1:0]          total_mispredict
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   occ_q, occ_d;
  logic                      upd_valid_q, upd_valid_d;
  logic [Direction_SIZE-1:0] upd_pc_q, upd_pc_d;
  logic                      upd_taken_q, upd_taken_d;
  logic                      upd_mis_q, upd_mis_d;
  logic                      orphan_q, orphan_d;
  logic [CNT_W-1:0]          tot_br_q, tot_br_d;
  logic [CNT_W-1:0]          tot_mis_q, tot_mis_d;

  logic [Direction_SIZE-1:0] pc_mem_q    [DEPTH];
  logic                      taken_mem_q [DEPTH];

  logic full, empty, pop, wr_en, mispredict, target_miss;
  logic head_taken;

  assign full       = (occ_q == OCC_FULL);
  assign empty      = (occ_q == '0);
  assign pred_ready = (state_q == ST_RUN) && !full;
  assign pop        = res_valid && !empty && (state_q == ST_RUN);
  assign head_taken = taken_mem_q[head_q];

`ifdef BRQ_TARGET_CHECK_EN
  logic [Direction_SIZE-1:0] target_mem_q [DEPTH];

  // Target storage exists only when target checking is built in.
  always_ff @(posedge clk) begin
    if (wr_en) target_mem_q[tail_q] <= pred_target;
  end

  assign target_miss = head_taken && res_taken && (target_mem_q[head_q] != res_target);
`else
  logic unused_target;
  assign unused_target = ^{pred_target, res_target};
  assign target_miss   = 1'b0;
`endif

  assign mispredict = pop && ((head_taken != res_taken) || target_miss);
  // The push offered in a flush cycle is wrong-path, so it is dropped.
  assign wr_en      = pred_valid && pred_ready && !mispredict;

  // Write an accepted prediction at the tail. The payload needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[tail_q]    <= pred_pc;
      taken_mem_q[tail_q] <= pred_taken;
    end
  end

  // Next-state, pointer, update and statistics logic.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    upd_valid_d = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    upd_mis_d   = upd_mis_q;
    orphan_d    = orphan_q;
    tot_br_d    = tot_br_q;
    tot_mis_d   = tot_mis_q;

    case (state_q)
      ST_RUN:     if (mispredict) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    if (pop) begin
      head_d      = head_q + PTR_ONE;
      upd_valid_d = 1'b1;
      upd_pc_d    = pc_mem_q[head_q];
      upd_taken_d = res_taken;
      upd_mis_d   = mispredict;
      if (!(&tot_br_q)) tot_br_d = tot_br_q + CNT_ONE;
      if (mispredict && !(&tot_mis_q)) tot_mis_d = tot_mis_q + CNT_ONE;
    end

    if (mispredict) begin
      tail_d = head_q + PTR_ONE;
      occ_d  = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end

    if (res_valid && !pop) orphan_d = 1'b1;
  end

  // State registers. An asynchronous clear drops all in-flight entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_mis_q   <= 1'b0;
      orphan_q    <= 1'b0;
      tot_br_q    <= '0;
      tot_mis_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      upd_mis_q   <= upd_mis_d;
      orphan_q    <= orphan_d;
      tot_br_q    <= tot_br_d;
      tot_mis_q   <= tot_mis_d;
    end
  end

  assign upd_valid        = upd_valid_q;
  assign upd_pc           = upd_pc_q;
  assign upd_taken        = upd_taken_q;
  assign upd_mispredict   = upd_mis_q;
  assign occupancy        = occ_q;
  assign res_orphan       = orphan_q;
  assign total_branch     = tot_br_q;
  assign total_mispredict = tot_mis_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Testbench for branch_resolve_queue: a reference queue model predicts
// acceptance, occupancy and statistics. Expected training updates go into a
// scoreboard and are matched against each upd_valid pulse.
module tb_branch_resolve_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 33;

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_valid, pred_taken, res_valid, res_taken;
  logic [DW-1:0] pred_pc, pred_target, res_target;
  logic          pred_ready, upd_valid, upd_taken, upd_mispredict, res_orphan;
  logic [DW-1:0] upd_pc;
  logic [3:0]    occupancy;
  logic [CW-1:0] total_branch, total_mispredict;

  branch_resolve_queue #(.Direction_SIZE(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .occupancy(occupancy),
    .res_orphan(res_orphan), .total_branch(total_branch),
    .total_mispredict(total_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] pc; logic taken; logic [DW-1:0] target; } pred_t;
  typedef struct { logic [DW-1:0] pc; logic taken; logic mis; } upd_t;

  pred_t m_q[$];
  upd_t  sb[$];
  logic  m_recover = 1'b0;
  logic  m_orphan  = 1'b0;
  int    m_br = 0, m_mis = 0;
  int    n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock of stimulus. Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic pv, input logic [DW-1:0] pc, input logic pt,
                      input logic [DW-1:0] ptg, input logic rv, input logic rt,
                      input logic [DW-1:0] rtg);
    logic ready_e, pop_e, mis_e, push_e;
    pred_t h;
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    #1;
    ready_e = !m_recover && (m_q.size() < DEPTH);
    check("pred_ready", pred_ready, ready_e);
    pop_e = rv && !m_recover && (m_q.size() > 0);
    mis_e = 1'b0;
    if (pop_e) begin
      h = m_q[0];
      mis_e = (h.taken != rt);
`ifdef BRQ_TARGET_CHECK_EN
      if (h.taken && rt && (h.target != rtg)) mis_e = 1'b1;
`endif
      sb.push_back('{pc: h.pc, taken: rt, mis: mis_e});
      m_br++;
      if (mis_e) m_mis++;
    end
    if (rv && !pop_e) m_orphan = 1'b1;
    push_e = pv && ready_e && !mis_e;
    @(posedge clk);
    if (pop_e) void'(m_q.pop_front());
    if (mis_e) m_q.delete();
    if (push_e) m_q.push_back('{pc: pc, taken: pt, target: ptg});
    m_recover = mis_e;
    #1;
    pred_valid = 1'b0; res_valid = 1'b0;
    check("occupancy", 64'(occupancy), 64'(m_q.size()));
    check("res_orphan", res_orphan, m_orphan);
    check("total_branch", 64'(total_branch), 64'(m_br));
    check("total_mispredict", 64'(total_mispredict), 64'(m_mis));
  endtask

  task automatic push(input logic [DW-1:0] pc, input logic t, input logic [DW-1:0] tg);
    step(1'b1, pc, t, tg, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve_ok();
    step(1'b0, '0, 1'b0, '0, 1'b1, m_q[0].taken, m_q[0].target);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Match each training update against the scoreboard, away from the edge.
  initial begin
    upd_t e;
    forever begin
      @(negedge clk);
      if (reset && upd_valid) begin
        if (sb.size() == 0) check("upd_spurious", 64'(upd_valid), 64'(0));
        else begin
          e = sb.pop_front();
          check("upd_pc", 64'(upd_pc), 64'(e.pc));
          check("upd_taken", upd_taken, e.taken);
          check("upd_mispredict", upd_mispredict, e.mis);
        end
      end
    end
  end

  initial begin
    logic rt;
    reset = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    #2;
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_upd_valid", upd_valid, 1'b0);
    check("rst_orphan", res_orphan, 1'b0);
    check("rst_total_branch", 64'(total_branch), 64'(0));
    check("rst_pred_ready", pred_ready, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Three in-order correct resolutions.
    push(32'h10, 1'b1, 32'h110);
    push(32'h20, 1'b0, 32'h0);
    push(32'h30, 1'b1, 32'h130);
    repeat (3) resolve_ok();
    idle();
    check("basic_total_branch", 64'(total_branch), 64'(3));
    check("basic_total_mis", 64'(total_mispredict), 64'(0));

    // Fill, refuse a 9th push, then pop and push together while full.
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i * 4), i[0], 32'h200 + 32'(i));
    check("full_occupancy", 64'(occupancy), 64'(8));
    push(32'h999, 1'b1, 32'h999);
    step(1'b1, 32'h998, 1'b1, 32'h998, 1'b1, m_q[0].taken, m_q[0].target);
    check("full_poppush_occ", 64'(occupancy), 64'(7));
    repeat (7) resolve_ok();
    idle();

    // Resolution on an empty queue.
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, '0);
    check("orphan_set", res_orphan, 1'b1);
    check("orphan_no_count", 64'(total_branch), 64'(11));

    // Direction mispredict while a 5th push is offered.
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i * 4), 1'b1, 32'h500);
    step(1'b1, 32'h4f0, 1'b1, 32'h500, 1'b1, 1'b0, '0);
    check("flush_occupancy", 64'(occupancy), 64'(0));
    check("flush_mis_count", 64'(total_mispredict), 64'(1));
    check("recover_ready", pred_ready, 1'b0);
    push(32'h4f4, 1'b1, 32'h500);
    check("after_recover_occ", 64'(occupancy), 64'(0));
    idle();

    // Target mismatch on a taken branch; expectation depends on the build.
    push(32'h40, 1'b1, 32'h100);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h104);
`ifdef BRQ_TARGET_CHECK_EN
    check("target_mis_count", 64'(total_mispredict), 64'(2));
`else
    check("target_mis_count", 64'(total_mispredict), 64'(1));
`endif
    idle();

    // Random mix of pushes and resolutions against the model.
    for (int i = 0; i < 60; i++) begin
      if (m_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        rt = m_q[0].taken;
        if ($urandom_range(0, 5) == 0) rt = ~rt;
        step($urandom_range(0, 1) == 1, 32'h1000 + 32'(i * 4), $urandom_range(0, 1) == 1,
             32'h2000 + 32'(i), 1'b1, rt,
             ($urandom_range(0, 7) == 0) ? 32'hdead : m_q[0].target);
      end else begin
        step(1'b1, 32'h1000 + 32'(i * 4), $urandom_range(0, 1) == 1, 32'h2000 + 32'(i),
             1'b0, 1'b0, '0);
      end
    end
    while (m_q.size() > 0) resolve_ok();
    idle(); idle();

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) push(32'h700 + 32'(i * 4), 1'b1, 32'h800);
    check("pre_reset_occ", 64'(occupancy), 64'(5));
    #2 reset = 1'b0;
    #1;
    check("async_rst_occ", 64'(occupancy), 64'(0));
    check("async_rst_branch", 64'(total_branch), 64'(0));
    check("async_rst_mis", 64'(total_mispredict), 64'(0));
    check("async_rst_upd", upd_valid, 1'b0);
    m_q.delete(); sb.delete();
    m_recover = 1'b0; m_orphan = 1'b0; m_br = 0; m_mis = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) idle();

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits directly downstream of the pshare predictor.
- Holds each issued prediction in order until the real outcome resolves.
- Compares the prediction against the outcome, emits a registered training update back to the predictor, and keeps branch and mispredict statistics.
- On a mispredict, discards all younger (wrong-path) predictions and stalls intake for one recovery cycle.

Parameters:
- Direction_SIZE, 32, width of PC and target addresses.
- DEPTH, 8, queue entries; power of two, minimum 2.
- CNT_W, 33, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pred_valid  in  1  prediction offered.
- pred_ready  out  1  queue accepts a prediction this cycle.
- pred_pc  in  Direction_SIZE  branch address.
- pred_taken  in  1  predicted direction.
- pred_target  in  Direction_SIZE  predicted target.
- res_valid  in  1  oldest branch resolved this cycle.
- res_taken  in  1  actual direction.
- res_target  in  Direction_SIZE  actual target.
- upd_valid  out  1  training update is valid.
- upd_pc  out  Direction_SIZE  address of the resolved branch.
- upd_taken  out  1  actual direction, forwarded to the predictor.
- upd_mispredict  out  1  the resolved prediction was wrong.
- occupancy  out  clog2(DEPTH)+1  current number of queued entries.
- res_orphan  out  1  sticky flag: a resolution arrived while the queue was empty.
- total_branch  out  CNT_W  count of resolved branches.
- total_mispredict  out  CNT_W  count of mispredicted branches.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and occupancy go to 0; FSM enters RUN.
  - All outputs go to 0, except pred_ready, which is 1 once RUN is active.
- Storage:
  - Circular buffer with separate head and tail pointers; each wraps modulo DEPTH.
  - Full: occupancy == DEPTH. Empty: occupancy == 0.
- Push:
  - Occurs when pred_valid && pred_ready; the entry is written at tail.
  - pred_ready = (state==RUN) && !full, computed combinationally.
  - When full, a push is refused even if a pop happens in the same cycle. There is no bypass.
- Pop:
  - Occurs when res_valid && !empty; the head entry is compared against the outcome.
  - Mispredict = (pred_taken != res_taken), OR (both taken AND pred_target != res_target).
- Update outputs, registered:
  - One cycle after a pop: upd_valid=1, with upd_pc, upd_taken and upd_mispredict taken from that pop.
  - upd_valid is 0 in every other cycle.
- Counters:
  - total_branch increments by 1 on every pop.
  - total_mispredict increments by 1 on every mispredicted pop.
  - Both saturate at all-ones.
- res_valid while empty: no pop, no update, res_orphan set to 1. It clears only on reset.
- Simultaneous push and non-mispredicting pop: both occur; occupancy is unchanged.
- Mispredict flush:
  - In the same cycle as the mispredicted pop, all remaining entries are discarded: tail <= head+1, and occupancy becomes 0 next cycle.
  - Any push offered in that cycle is dropped, because it is wrong-path.
  - The FSM goes RUN -> RECOVER.
- RECOVER:
  - Lasts exactly one cycle, with pred_ready=0.
  - res_valid in this cycle is treated as an empty-queue resolution and sets res_orphan.
  - The FSM then returns to RUN.
- Reset asserted mid-operation: all state clears immediately; in-flight entries are lost, and no update is emitted for them.

Optional Feature:
- BRQ_TARGET_CHECK_EN
  - Defined: the target comparison is part of the mispredict rule above.
  - Undefined: mispredict = direction mismatch only. The target fields are neither stored nor compared, pred_target and res_target are ignored, and storage shrinks accordingly.

Test Plan:
- Reset, then push 3 predictions (pc 0x10/0x20/0x30, taken=1, 0, 1) and resolve all three correctly with matching targets -> three upd_valid pulses in order with pc 0x10/0x20/0x30, upd_mispredict=0, total_branch=3, total_mispredict=0.
- Push 8 entries with no resolutions -> occupancy=8, pred_ready=0; a 9th push is refused. Then pop and push in the same cycle -> push still refused, occupancy=7.
- Push 4 entries; resolve the head with res_taken opposite to the prediction while pushing a 5th -> upd_mispredict=1 next cycle, occupancy=0, pred_ready=0 for one cycle, total_mispredict=1, the 5th push is absent.
- With BRQ_TARGET_CHECK_EN: predict taken to 0x100, resolve taken to 0x104 -> upd_mispredict=1. Without the macro, the same stimulus -> upd_mispredict=0.
- res_valid on an empty queue -> no upd_valid, res_orphan=1, total_branch unchanged.
- Assert reset with 5 entries queued -> occupancy=0, counters=0, upd_valid=0 asynchronously, with no trailing update after reset is released.
